// File: rtl/floo_simple_rob.sv
// Simple reorder buffer: slots are reserved in order at allocation time, filled by
// out-of-order responses, and released strictly in allocation order from the head.
module floo_simple_rob #(
  parameter int unsigned RoBSize   = 8,   // power of two, at least 2
  parameter int unsigned DataWidth = 64,
  localparam int unsigned IdxWidth = $clog2(RoBSize),
  localparam int unsigned CntWidth = $clog2(RoBSize + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // slot allocation
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  output logic [IdxWidth-1:0]  alloc_idx_o,
  // out-of-order responses
  input  logic                 rsp_valid_i,
  output logic                 rsp_ready_o,
  input  logic [IdxWidth-1:0]  rsp_idx_i,
  input  logic [DataWidth-1:0] rsp_data_i,
  // in-order release
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [DataWidth-1:0] out_data_o,
  // status
  output logic [CntWidth-1:0]  count_o,
  output logic                 err_o
);

  logic [IdxWidth-1:0]  head_q, tail_q;
  logic [CntWidth-1:0]  count_q;
  logic [RoBSize-1:0]   filled_q, filled_d;
  logic [DataWidth-1:0] data_q [RoBSize];
  logic                 err_q;

  logic                alloc_fire, out_fire;
  logic [IdxWidth-1:0] rsp_offset;
  logic                rsp_in_window, rsp_legal;

  // A release in the same cycle never frees room for an allocation: readiness
  // depends on the registered count only.
  assign alloc_ready_o = count_q < CntWidth'(RoBSize);
  assign alloc_idx_o   = tail_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;

  // Slots are reserved up front, so a response can always be absorbed.
  assign rsp_ready_o   = 1'b1;

  assign out_valid_o   = filled_q[head_q] && (count_q != '0);
  assign out_data_o    = data_q[head_q];
  assign out_fire      = out_valid_o && out_ready_i;

  // Distance from head, modulo RoBSize, must be below the occupancy; an empty
  // buffer therefore rejects every response.
  assign rsp_offset    = rsp_idx_i - head_q;
  assign rsp_in_window = CntWidth'(rsp_offset) < count_q;
  assign rsp_legal     = rsp_valid_i && rsp_in_window && !filled_q[rsp_idx_i];

  assign count_o       = count_q;
  assign err_o         = err_q;

  // The three updates always target distinct slots: the tail lies outside the
  // window, and a legal response needs an empty slot while release needs a full one.
  always_comb begin
    // NOTE: default assignment first so every path drives filled_d and no latch is inferred.
    filled_d = filled_q;
    if (alloc_fire) filled_d[tail_q]    = 1'b0;
    if (out_fire)   filled_d[head_q]    = 1'b0;
    if (rsp_legal)  filled_d[rsp_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments so all state updates see pre-edge values.
    if (rst_i) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      filled_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (alloc_fire) tail_q <= tail_q + 1'b1;
      if (out_fire)   head_q <= head_q + 1'b1;
      count_q  <= count_q + CntWidth'(alloc_fire) - CntWidth'(out_fire);
      filled_q <= filled_d;
      err_q    <= rsp_valid_i && !rsp_legal;
    end
  end

  // NOTE: payload storage has no reset; the filled bits alone qualify its contents.
  always_ff @(posedge clk_i) begin
    if (rsp_legal) data_q[rsp_idx_i] <= rsp_data_i;
  end

endmodule
